power_mode_ctrl: RTL
====================

POWER_MODE_CTRL -- requirements
Module: power_mode_ctrl

Interface
REQ-001 The block SHALL expose parameter ON_HOLD_CYCLES, default 100_000_000, meaning consecutive synchronized-high cycles of power_btn required to power on (1 s at 100 MHz).
REQ-002 The block SHALL expose parameter OFF_HOLD_CYCLES, default 50_000_000, meaning consecutive synchronized-high cycles of power_btn required to power off.
REQ-003 The block SHALL expose parameter MODE_W, default 2, meaning width of the mode selection and mode output.
REQ-004 The block SHALL expose parameter MODE_STABLE_CYCLES, default 1_000_000, meaning consecutive cycles mode_sel must hold one value before it is accepted.
REQ-005 clk  input  1  system clock, all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 power_btn  input  1  raw power push-button, asynchronous to clk, active-high.
REQ-008 mode_sel  input  MODE_W  raw mode switches, asynchronous to clk.
REQ-009 vehicle_idle  input  1  high when the vehicle is stationary, which permits a mode change.
REQ-010 power_state  output  1  1 = powered on.
REQ-011 mode  output  MODE_W  accepted driving mode; 0 = no mode.
REQ-012 power_on_pulse  output  1  one-cycle pulse on the off-to-on transition.
REQ-013 power_off_pulse  output  1  one-cycle pulse on the on-to-off transition.
REQ-014 mode_changed  output  1  one-cycle pulse when mode takes a new value while powered on.

Function
REQ-015 power_btn and each mode_sel bit SHALL pass through a 2-flop synchronizer; all "synchronized" values below refer to the second-flop output.
REQ-016 The power FSM SHALL have states OFF, ARM_ON, ON, ARM_OFF and WAIT_REL, plus a hold counter wide enough for max(ON_HOLD_CYCLES, OFF_HOLD_CYCLES).
REQ-017 OFF: when the synchronized button is high -> ARM_ON with counter = 1; otherwise stay in OFF.
REQ-018 ARM_ON: when the button is high and counter = ON_HOLD_CYCLES-1 -> ON, with power_state = 1 and power_on_pulse = 1 on that edge; when high but the count is not yet reached -> counter increments; when the button is low -> OFF and counter cleared.
REQ-019 ON -> ARM_OFF on button high; ARM_OFF uses OFF_HOLD_CYCLES with the same counting rule as ARM_ON. On completion: power_state = 0, power_off_pulse = 1, next state WAIT_REL. On early release: back to ON.
REQ-020 ON entry from ARM_ON SHALL also go through WAIT_REL semantics: the button must be sampled low once before ARM_OFF can start, so one continuous hold never toggles power twice.
REQ-021 WAIT_REL: hold power_state unchanged; on button low -> OFF or ON according to power_state.
REQ-022 While power_state = 0, mode SHALL be 0, mode_changed SHALL be 0, and the stability counter SHALL be cleared.
REQ-023 While power_state = 1, a candidate register SHALL track synchronized mode_sel. Any change of the candidate reloads the stability counter to 0. Otherwise the counter increments and saturates at MODE_STABLE_CYCLES.
REQ-024 The candidate SHALL be accepted on the edge where the counter equals MODE_STABLE_CYCLES, candidate != mode, and vehicle_idle = 1. On acceptance: mode <= candidate and mode_changed = 1 for one cycle.
REQ-025 A stable candidate that differs from mode SHALL wait, without re-counting, until vehicle_idle rises, then be accepted on that edge.
REQ-026 Power-off SHALL force mode to 0 on the same edge that power_state falls, without asserting mode_changed.
REQ-027 Power-on SHALL leave mode at 0; a stable non-zero selection SHALL be adopted per REQ-024.
REQ-028 Pulse outputs SHALL be registered and never assert for more than one consecutive cycle.

Reset
REQ-029 While rst = 0, and immediately on its falling edge: FSM = OFF, all counters = 0, synchronizers = 0, power_state = 0, mode = 0, and all pulses = 0.
REQ-030 Reset asserted mid-hold or mid-stabilization SHALL abandon that operation. After release, a new full hold or stability period is required.

Verification (ON_HOLD=4, OFF_HOLD=3, MODE_STABLE=2, MODE_W=2)
REQ-031 Hold power_btn 3 synced cycles, then release -> power_state stays 0, no pulse.
REQ-032 Hold power_btn continuously 10 cycles -> power_on_pulse once (4th synced-high cycle), power_state = 1, no power-off while still held.
REQ-033 Powered on, vehicle_idle = 1, mode_sel = 2'b10 held -> mode = 2'b10 and a single mode_changed after 2 stable cycles. Toggle mode_sel 2'b01 for 1 cycle then back to 2'b10 -> no change.
REQ-034 Powered on, vehicle_idle = 0, mode_sel = 2'b11 held 5 cycles -> mode unchanged. Raise vehicle_idle -> mode = 2'b11 on that edge with mode_changed.
REQ-035 Powered on with mode 2'b11, release then hold power_btn 3 cycles -> power_off_pulse, power_state = 0, mode = 0 on the same edge, no mode_changed.
REQ-036 Drop rst during ARM_ON at count 2 -> all outputs 0 asynchronously. After release, 4 fresh held cycles are needed to power on.

Source files
------------

// File: rtl/power_mode_ctrl_if.sv
// Bundle of the power/mode controller's functional signals. The controller
// connects through the slave modport. The stimulus side connects through the
// master modport.
interface power_mode_ctrl_if #(
    parameter int unsigned MODE_W = 2
);
    logic              power_btn;
    logic [MODE_W-1:0] mode_sel;
    logic              vehicle_idle;
    logic              power_state;
    logic [MODE_W-1:0] mode;
    logic              power_on_pulse;
    logic              power_off_pulse;
    logic              mode_changed;

    // Stimulus side: drives the raw inputs and observes the outputs.
    modport master (
        output power_btn,
        output mode_sel,
        output vehicle_idle,
        input  power_state,
        input  mode,
        input  power_on_pulse,
        input  power_off_pulse,
        input  mode_changed
    );

    // Controller side: reads the raw inputs and drives the outputs.
    modport slave (
        input  power_btn,
        input  mode_sel,
        input  vehicle_idle,
        output power_state,
        output mode,
        output power_on_pulse,
        output power_off_pulse,
        output mode_changed
    );
endinterface

// File: rtl/power_mode_ctrl.sv
// Power / driving-mode controller.
// - A long press of the power button switches power on.
// - A second long press switches power off.
// - The button has to be released between the two presses.
// - While power is on, a mode selection is adopted under two conditions:
//   it has been stable for MODE_STABLE_CYCLES, and the vehicle is idle.
// - Every output is a register.
module power_mode_ctrl #(
    parameter int unsigned ON_HOLD_CYCLES     = 100_000_000,
    parameter int unsigned OFF_HOLD_CYCLES    = 50_000_000,
    parameter int unsigned MODE_W             = 2,
    parameter int unsigned MODE_STABLE_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    power_mode_ctrl_if.slave bus
);

    localparam int unsigned HOLD_MAX = (ON_HOLD_CYCLES > OFF_HOLD_CYCLES) ?
                                       ON_HOLD_CYCLES : OFF_HOLD_CYCLES;
    localparam int unsigned CNT_W    = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;
    localparam int unsigned STAB_W   = (MODE_STABLE_CYCLES > 1) ?
                                       $clog2(MODE_STABLE_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  ON_LAST   = CNT_W'(ON_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  OFF_LAST  = CNT_W'(OFF_HOLD_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_ZERO = {STAB_W{1'b0}};
    localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
    localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(MODE_STABLE_CYCLES);
    localparam logic [MODE_W-1:0] MODE_NONE = {MODE_W{1'b0}};

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_ARM_ON   = 3'd1,
        ST_ON       = 3'd2,
        ST_ARM_OFF  = 3'd3,
        ST_WAIT_REL = 3'd4
    } pwr_state_t;

    // Synchronizers
    logic              btn_meta_r;
    logic              btn_sync_r;
    logic [MODE_W-1:0] mode_meta_r;
    logic [MODE_W-1:0] mode_sync_r;

    // Power FSM
    pwr_state_t        state_r;
    pwr_state_t        state_nxt_s;
    logic [CNT_W-1:0]  hold_cnt_r;
    logic [CNT_W-1:0]  hold_cnt_nxt_s;
    logic              power_state_r;
    logic              power_state_nxt_s;
    logic              on_pulse_r;
    logic              on_pulse_nxt_s;
    logic              off_pulse_r;
    logic              off_pulse_nxt_s;

    // Mode selection
    logic [MODE_W-1:0] cand_r;
    logic [MODE_W-1:0] mode_r;
    logic [STAB_W-1:0] stab_cnt_r;
    logic              mode_changed_r;
    logic              accept_s;

    // Two-flop synchronizers for the raw button and the mode switches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_meta_r  <= 1'b0;
            btn_sync_r  <= 1'b0;
            mode_meta_r <= MODE_NONE;
            mode_sync_r <= MODE_NONE;
        end else begin
            btn_meta_r  <= bus.power_btn;
            btn_sync_r  <= btn_meta_r;
            mode_meta_r <= bus.mode_sel;
            mode_sync_r <= mode_meta_r;
        end
    end

    // Power FSM state, hold counter and registered power outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_OFF;
            hold_cnt_r    <= CNT_ZERO;
            power_state_r <= 1'b0;
            on_pulse_r    <= 1'b0;
            off_pulse_r   <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            hold_cnt_r    <= hold_cnt_nxt_s;
            power_state_r <= power_state_nxt_s;
            on_pulse_r    <= on_pulse_nxt_s;
            off_pulse_r   <= off_pulse_nxt_s;
        end
    end

    // Power FSM next state. A completed hold always passes through WAIT_REL,
    // so that one continuous press can never toggle power twice.
    always_comb begin
        state_nxt_s       = state_r;
        hold_cnt_nxt_s    = hold_cnt_r;
        power_state_nxt_s = power_state_r;
        on_pulse_nxt_s    = 1'b0;
        off_pulse_nxt_s   = 1'b0;
        case (state_r)
            ST_OFF: begin
                if (btn_sync_r) begin
                    state_nxt_s    = ST_ARM_ON;
                    hold_cnt_nxt_s = CNT_ONE;
                end else begin
                    hold_cnt_nxt_s = CNT_ZERO;
                end
            end
            ST_ARM_ON: begin
                if (!btn_sync_r) begin
                    state_nxt_s    = ST_OFF;
                    hold_cnt_nxt_s = CNT_ZERO;
                end else if (hold_cnt_r == ON_LAST) begin
                    state_nxt_s       = ST_WAIT_REL;
                    hold_cnt_nxt_s    = CNT_ZERO;
                    power_state_nxt_s = 1'b1;
                    on_pulse_nxt_s    = 1'b1;
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r + CNT_ONE;
                end
            end
            ST_ON: begin
                if (btn_sync_r) begin
                    state_nxt_s    = ST_ARM_OFF;
                    hold_cnt_nxt_s = CNT_ONE;
                end else begin
                    hold_cnt_nxt_s = CNT_ZERO;
                end
            end
            ST_ARM_OFF: begin
                if (!btn_sync_r) begin
                    state_nxt_s    = ST_ON;
                    hold_cnt_nxt_s = CNT_ZERO;
                end else if (hold_cnt_r == OFF_LAST) begin
                    state_nxt_s       = ST_WAIT_REL;
                    hold_cnt_nxt_s    = CNT_ZERO;
                    power_state_nxt_s = 1'b0;
                    off_pulse_nxt_s   = 1'b1;
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r + CNT_ONE;
                end
            end
            ST_WAIT_REL: begin
                hold_cnt_nxt_s = CNT_ZERO;
                if (!btn_sync_r) begin
                    state_nxt_s = power_state_r ? ST_ON : ST_OFF;
                end else begin
                    state_nxt_s = ST_WAIT_REL;
                end
            end
            default: begin
                state_nxt_s       = ST_OFF;
                hold_cnt_nxt_s    = CNT_ZERO;
                power_state_nxt_s = 1'b0;
            end
        endcase
    end

    // A stable candidate is adopted only while powered on with the vehicle
    // idle. It is never adopted on the edge where power is being removed.
    always_comb begin
        accept_s = 1'b0;
        if (power_state_r && !off_pulse_nxt_s && (stab_cnt_r == STAB_MAX) &&
            (cand_r != mode_r) && bus.vehicle_idle) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Candidate tracking, stability counting and the accepted mode.
    // Power-off clears the mode silently, on the same edge as power_state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand_r         <= MODE_NONE;
            mode_r         <= MODE_NONE;
            stab_cnt_r     <= STAB_ZERO;
            mode_changed_r <= 1'b0;
        end else if (off_pulse_nxt_s || !power_state_r) begin
            cand_r         <= MODE_NONE;
            mode_r         <= MODE_NONE;
            stab_cnt_r     <= STAB_ZERO;
            mode_changed_r <= 1'b0;
        end else begin
            if (mode_sync_r != cand_r) begin
                cand_r     <= mode_sync_r;
                stab_cnt_r <= STAB_ZERO;
            end else if (stab_cnt_r != STAB_MAX) begin
                stab_cnt_r <= stab_cnt_r + STAB_ONE;
            end else begin
                stab_cnt_r <= stab_cnt_r;
            end
            if (accept_s) begin
                mode_r <= cand_r;
            end else begin
                mode_r <= mode_r;
            end
            mode_changed_r <= accept_s;
        end
    end

    assign bus.power_state     = power_state_r;
    assign bus.mode            = mode_r;
    assign bus.power_on_pulse  = on_pulse_r;
    assign bus.power_off_pulse = off_pulse_r;
    assign bus.mode_changed    = mode_changed_r;

endmodule
